// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_reader_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

  localparam int BUF_DEPTH = 3;

endpackage

// File: rtl/bram_rd_skid_buf.sv
// Three-entry shift FIFO of {data, last}; entry 0 is always the head, so the
// stream outputs come straight from flops.
module bram_rd_skid_buf
  import bram_reader_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic         head_valid,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         pop_ok;
  logic [1:0]   wr_idx;
  logic [1:0]   occ_next;

  assign pop_ok = pop && head_valid;
  assign head   = mem[0];

  // A same-cycle pop shifts everything down, so the write lands one slot lower.
  always_comb begin
    wr_idx   = pop_ok ? occ - 2'd1 : occ;
    occ_next = occ + 2'(push) - 2'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 2'd0;
      head_valid <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      occ        <= occ_next;
      head_valid <= (occ_next != 2'd0);
      if (pop_ok) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          if (wr_idx == 2'(i)) mem[i] <= din;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && occ == 2'(BUF_DEPTH)))
    else $error("bram_rd_skid_buf: push into full buffer");

endmodule

// File: rtl/bram_stream_reader.sv
// BRAM read master: issues reads, absorbs the 1-cycle read latency and emits a
// valid/ready stream with tlast. Optional stall counter: BRAM_READER_STALL_CNT_EN.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int RAM_WIDTH = 64,
  parameter int RAM_DEPTH = 512,
  parameter int ADDR_W    = $clog2(RAM_DEPTH),
  parameter int LEN_W     = $clog2(RAM_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_enb,
  output logic [ADDR_W-1:0]    addrb,
  input  logic [RAM_WIDTH-1:0] doutb,
  output logic [RAM_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast
`ifdef BRAM_READER_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  rd_state_t         state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  issue_cnt;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        occ;
  logic              hs;
  logic              start_ok;

  assign hs       = m_tvalid && m_tready;
  assign start_ok = (state == IDLE) && start && (length != '0);
  assign addrb    = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = READ;
      READ:    if (issue_cnt == '0) state_next = DRAIN;
      DRAIN:   if (hs && m_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reads in flight and words buffered together may never exceed the buffer depth.
  always_comb begin
    busy   = (state != IDLE);
    rd_enb = (state == READ) && (issue_cnt != '0) &&
             ((3'(occ) + 3'(inflight)) < 3'(BUF_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      issue_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= rd_enb;
      inflight_last <= rd_enb && (issue_cnt == LEN_W'(1));
      done          <= ((state == IDLE) && start && (length == '0)) ||
                       ((state == DRAIN) && hs && m_tlast);
      if (start_ok) begin
        addr      <= start_addr;
        issue_cnt <= length;
      end else if (rd_enb) begin
        addr      <= (addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
        issue_cnt <= issue_cnt - LEN_W'(1);
      end
    end
  end

  bram_rd_skid_buf #(
    .W (RAM_WIDTH + 1)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .din        ({doutb, inflight_last}),
    .pop        (hs),
    .occ        (occ),
    .head_valid (m_tvalid),
    .head       ({m_tdata, m_tlast})
  );

`ifdef BRAM_READER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (m_tvalid && !m_tready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a queue model of the expected beats and read
// addresses, checked every cycle, plus literal expectations for fixed scenarios.
module tb_bram_stream_reader;

  localparam int RAM_WIDTH = 64;
  localparam int RAM_DEPTH = 512;
  localparam int ADDR_W    = 9;
  localparam int LEN_W     = 10;
  localparam int W         = RAM_WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [ADDR_W-1:0]    start_addr = '0;
  logic [LEN_W-1:0]     length = '0;
  logic                 busy, done, rd_enb, m_tvalid, m_tlast;
  logic [ADDR_W-1:0]    addrb;
  logic [RAM_WIDTH-1:0] doutb = '0;
  logic [RAM_WIDTH-1:0] m_tdata;
  logic                 m_tready;
`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0]          stall_cnt;
`endif

  bram_stream_reader #(
    .RAM_WIDTH (RAM_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .rd_enb     (rd_enb),
    .addrb      (addrb),
    .doutb      (doutb),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast)
`ifdef BRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // ---------------- clock / BRAM model ----------------
  always #5 clk = ~clk;

  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  always @(posedge clk) if (rd_enb) doutb <= ram[addrb];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [W-1:0]      got_q[$];
  bit                busy_exp = 1'b0;
  bit                done_exp = 1'b0;
  bit                stalled = 1'b0;
  logic [W-1:0]      held = '0;
  int                outstanding = 0;

  always @(negedge clk) begin
    bit hs;
    bit last_hs;
    int a;
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      busy_exp    = 1'b0;
      done_exp    = 1'b0;
      stalled     = 1'b0;
      outstanding = 0;
    end else begin
      chk_eq("busy", W'(busy), W'(busy_exp));
      chk_eq("done", W'(done), W'(done_exp));
      if (rd_enb) begin
        chk_eq("issue_limit", W'(outstanding < 3), W'(1));
        if (addr_q.size() == 0) chk_eq("unexpected_read", W'(rd_enb), W'(0));
        else chk_eq("addrb", W'(addrb), W'(addr_q.pop_front()));
      end
      if (stalled) begin
        chk_eq("stall_valid", W'(m_tvalid), W'(1));
        chk_eq("stall_hold", {m_tdata, m_tlast}, held);
      end
      hs      = m_tvalid && m_tready;
      last_hs = 1'b0;
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_beat", W'(m_tvalid), W'(0));
        end else begin
          chk_eq("beat", {m_tdata, m_tlast}, exp_q[0]);
          if (hs) begin
            void'(exp_q.pop_front());
            last_hs = (exp_q.size() == 0);
            got_q.push_back({m_tdata, m_tlast});
          end
        end
      end
      stalled     = m_tvalid && !m_tready;
      held        = {m_tdata, m_tlast};
      outstanding = outstanding + int'(rd_enb) - int'(hs);
      done_exp    = (busy_exp && last_hs) || (!busy_exp && start && length == '0);
      if (!busy_exp && start && length != '0) begin
        busy_exp = 1'b1;
        for (int k = 0; k < int'(length); k++) begin
          a = (int'(start_addr) + k) % RAM_DEPTH;
          exp_q.push_back({ram[a], 1'(k == int'(length) - 1)});
          addr_q.push_back(ADDR_W'(a));
        end
      end else if (busy_exp && last_hs) begin
        busy_exp = 1'b0;
      end
    end
  end

  // ---------------- ready driver ----------------
  int ready_mode = 0;  // 0: always 1, 1: 1,0,0 pattern, 2: random, 3: hold 0
  initial begin
    int phase = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (phase % 3 == 0);
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
      phase++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = a;
    length = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #2;
      if (done) break;
      n++;
    end
    chk_eq(name, W'(n < 3000), W'(1));
    chk_eq("queue_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = RAM_WIDTH'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = {$urandom, $urandom};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    fill_ramp();
    repeat (3) @(posedge clk);
    #2;
    chk_eq("rst_busy", W'(busy), W'(0));
    chk_eq("rst_rd_enb", W'(rd_enb), W'(0));
    chk_eq("rst_valid", W'(m_tvalid), W'(0));
    chk_eq("rst_tdata", {m_tdata, m_tlast}, W'(0));
    chk_eq("rst_addrb", W'(addrb), W'(0));
    rst = 1'b0;

    // 1: basic read, latency and tlast
    ready_mode = 0;
    do_start(9'h010, 10'd4);
    #1;
    chk_eq("t1_rd_enb_c1", W'(rd_enb), W'(1));
    chk_eq("t1_busy_c1", W'(busy), W'(1));
    chk_eq("t1_valid_c1", W'(m_tvalid), W'(0));
    @(posedge clk);
    #2;
    chk_eq("t1_valid_c2", W'(m_tvalid), W'(0));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      chk_eq("t1_valid", W'(m_tvalid), W'(1));
      chk_eq("t1_beat", {m_tdata, m_tlast}, {64'(16 + k), 1'(k == 3)});
    end
    @(posedge clk);
    #2;
    chk_eq("t1_done", W'(done), W'(1));
    chk_eq("t1_busy_end", W'(busy), W'(0));

    // 2: address wrap
    base = got_q.size();
    do_start(9'h1FE, 10'd4);
    wait_done("t2_timeout");
    chk_eq("t2_count", W'(got_q.size() - base), W'(4));
    chk_eq("t2_b0", got_q[base], {64'h1FE, 1'b0});
    chk_eq("t2_b1", got_q[base+1], {64'h1FF, 1'b0});
    chk_eq("t2_b2", got_q[base+2], {64'h000, 1'b0});
    chk_eq("t2_b3", got_q[base+3], {64'h001, 1'b1});

    // 3: back-pressure, patterned then random
    fill_random();
    ready_mode = 1;
    base = got_q.size();
    do_start(9'h100, 10'd8);
    wait_done("t3_pattern_timeout");
    chk_eq("t3_pattern_count", W'(got_q.size() - base), W'(8));
    ready_mode = 2;
    base = got_q.size();
    do_start(9'h1F9, 10'd8);
    wait_done("t3_random_timeout");
    chk_eq("t3_random_count", W'(got_q.size() - base), W'(8));
    chk_eq("t3_random_first", got_q[base], {ram[9'h1F9], 1'b0});

    // 4: zero length
    ready_mode = 0;
    do_start(9'h033, 10'd0);
    #1;
    chk_eq("t4_done", W'(done), W'(1));
    chk_eq("t4_busy", W'(busy), W'(0));
    chk_eq("t4_rd_enb", W'(rd_enb), W'(0));
    chk_eq("t4_valid", W'(m_tvalid), W'(0));
    @(posedge clk);
    #2;
    chk_eq("t4_done_clear", W'(done), W'(0));

    // 5: reset mid-transfer
    fill_ramp();
    base = got_q.size();
    do_start(9'h050, 10'd10);
    n = 0;
    while (got_q.size() < base + 3 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk_eq("t5_three_beats", W'(n < 100), W'(1));
    #1;
    rst = 1'b1;
    #1;
    chk_eq("t5_busy", W'(busy), W'(0));
    chk_eq("t5_rd_enb", W'(rd_enb), W'(0));
    chk_eq("t5_valid", W'(m_tvalid), W'(0));
    chk_eq("t5_tdata", {m_tdata, m_tlast}, W'(0));
    chk_eq("t5_addrb", W'(addrb), W'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = got_q.size();
    do_start(9'h020, 10'd2);
    wait_done("t5_timeout");
    chk_eq("t5_count", W'(got_q.size() - base), W'(2));
    chk_eq("t5_b0", got_q[base], {64'h20, 1'b0});
    chk_eq("t5_b1", got_q[base+1], {64'h21, 1'b1});

    // 6: start ignored while busy, stall counting
    fill_random();
    ready_mode = 3;
    base = got_q.size();
    do_start(9'h0A0, 10'd8);
    n = 0;
    while (!m_tvalid && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk_eq("t6_valid_seen", W'(n < 20), W'(1));
`ifdef BRAM_READER_STALL_CNT_EN
    chk_eq("t6_stall_zero", W'(stall_cnt), W'(0));
`endif
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = 9'h000;
    length = 10'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef BRAM_READER_STALL_CNT_EN
    chk_eq("t6_stall_cnt", W'(stall_cnt), W'(5));
`endif
    ready_mode = 0;
    wait_done("t6_timeout");
    chk_eq("t6_count", W'(got_q.size() - base), W'(8));
    chk_eq("t6_first", got_q[base], {ram[9'h0A0], 1'b0});

    // random transfers, including a full-depth wrapping read
    for (int t = 0; t < 6; t++) begin
      fill_random();
      ready_mode = 2;
      do_start(ADDR_W'($urandom_range(0, RAM_DEPTH - 1)), LEN_W'($urandom_range(1, 24)));
      wait_done("rand_timeout");
    end
    ready_mode = 0;
    base = got_q.size();
    do_start(9'h155, 10'd512);
    wait_done("full_timeout");
    chk_eq("full_count", W'(got_q.size() - base), W'(512));
    chk_eq("full_last", got_q[base+511], {ram[9'h154], 1'b1});

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
